id_stage_hz: RTL and testbench

Parametrised decode stage with hazard handling: decodes the IF/ID instruction, reads a reset-cleared register file, generates the sign-extended immediate and control bits, and registers everything into the ID/EX pipeline register. Unlike the first-generation decode stage it has a configurable data width, a valid bit, load-use stall detection, branch flush, x0 protection and a saturating bubble counter. It sits between the IF/ID register and EX; `stall_o` goes back to IF to freeze the PC and the IF/ID register.

---
 rtl/id_stage_hz.sv | 246 ++++++++++++++++++++++++
 tb/tb_id_stage_hz.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_hz.sv
// id_stage_hz: decode stage with hazard handling.
// Decodes the IF/ID instruction, reads a reset-cleared 32 x XLEN register file,
// builds the sign-extended immediate and control bits, and registers them into
// the ID/EX pipeline register. Detects load-use hazards (stall_o back to IF),
// turns flushes and stalls into bubbles, and counts bubbles with saturation.
//
// Optional feature: define ID_WB_BYPASS_EN to make a same-cycle writeback
// visible to the operand read (write-through). Undefined: the read returns the
// pre-write register value.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   instr_ifid, pc_ifid,        IF/ID instruction, PC and valid bit
//   valid_ifid
//   flush_i                     branch taken in EX; kill the ID instruction
//   wb_we, wb_rd, wb_data       register file write port
//   stall_o                     combinational load-use stall to IF
//   *_idex                      registered ID/EX payload and control bits
//   bubble_cnt                  saturating count of inserted bubbles
module id_stage_hz #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr_ifid,
    input  logic [XLEN-1:0]  pc_ifid,
    input  logic             valid_ifid,
    input  logic             flush_i,
    input  logic             wb_we,
    input  logic [4:0]       wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    output logic             stall_o,
    output logic             valid_idex,
    output logic [XLEN-1:0]  rs1_data_idex,
    output logic [XLEN-1:0]  rs2_data_idex,
    output logic [XLEN-1:0]  imm_idex,
    output logic [XLEN-1:0]  pc_idex,
    output logic [31:0]      instr_idex,
    output logic [4:0]       rd_idex,
    output logic [4:0]       rs1_idex,
    output logic [4:0]       rs2_idex,
    output logic             branch_idex,
    output logic             memread_idex,
    output logic             mem2reg_idex,
    output logic             memwrite_idex,
    output logic             alusrc_idex,
    output logic             regwrite_idex,
    output logic [1:0]       aluop_idex,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam int unsigned NREG = 32;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [CNT_W-1:0] BUB_MAX = '1;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            branch;
        logic            memread;
        logic            mem2reg;
        logic            memwrite;
        logic            alusrc;
        logic            regwrite;
        logic [1:0]      aluop;
    } idex_t;

    logic [XLEN-1:0]  rf_q [NREG];
    idex_t            idex_q, idex_d;
    logic [CNT_W-1:0] bubble_q, bubble_d;

    logic [6:0]       opcode;
    logic [4:0]       rd_f, rs1_f, rs2_f;
    logic             use_rs1, use_rs2;
    logic             dec_branch, dec_memread, dec_mem2reg, dec_memwrite;
    logic             dec_alusrc, dec_regwrite;
    logic [1:0]       dec_aluop;
    logic [XLEN-1:0]  dec_imm;
    logic [XLEN-1:0]  rs1_val, rs2_val;
    logic             stall_c;

    assign opcode = instr_ifid[6:0];
    assign rd_f   = instr_ifid[11:7];
    assign rs1_f  = instr_ifid[19:15];
    assign rs2_f  = instr_ifid[24:20];

    // Register file: x0 is never written, so it stays at its reset value of 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_we && (wb_rd != 5'd0)) begin
            rf_q[wb_rd] <= wb_data;
        end
    end

    // Opcode decode: control bits, source-register use and immediate.
    always_comb begin
        dec_branch   = 1'b0;
        dec_memread  = 1'b0;
        dec_mem2reg  = 1'b0;
        dec_memwrite = 1'b0;
        dec_alusrc   = 1'b0;
        dec_regwrite = 1'b0;
        dec_aluop    = 2'b00;
        use_rs1      = 1'b0;
        use_rs2      = 1'b0;
        dec_imm      = '0;
        unique case (opcode)
            OP_R: begin
                dec_regwrite = 1'b1;
                dec_aluop    = 2'b10;
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
            end
            OP_I: begin
                dec_alusrc   = 1'b1;
                dec_regwrite = 1'b1;
                dec_aluop    = 2'b11;
                use_rs1      = 1'b1;
                dec_imm      = {{(XLEN-12){instr_ifid[31]}}, instr_ifid[31:20]};
            end
            OP_LOAD: begin
                dec_alusrc   = 1'b1;
                dec_memread  = 1'b1;
                dec_mem2reg  = 1'b1;
                dec_regwrite = 1'b1;
                use_rs1      = 1'b1;
                dec_imm      = {{(XLEN-12){instr_ifid[31]}}, instr_ifid[31:20]};
            end
            OP_STORE: begin
                dec_alusrc   = 1'b1;
                dec_memwrite = 1'b1;
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
                dec_imm      = {{(XLEN-12){instr_ifid[31]}}, instr_ifid[31:25],
                                instr_ifid[11:7]};
            end
            OP_BRANCH: begin
                dec_branch   = 1'b1;
                dec_aluop    = 2'b01;
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
                dec_imm      = {{(XLEN-13){instr_ifid[31]}}, instr_ifid[31], instr_ifid[7],
                                instr_ifid[30:25], instr_ifid[11:8], 1'b0};
            end
            default: ;
        endcase
    end

    // Operand read; x0 is forced to zero independently of the array contents.
    always_comb begin
        rs1_val = (rs1_f == 5'd0) ? '0 : rf_q[rs1_f];
        rs2_val = (rs2_f == 5'd0) ? '0 : rf_q[rs2_f];
`ifdef ID_WB_BYPASS_EN
        if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs1_f)) begin
            rs1_val = wb_data;
        end
        if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs2_f)) begin
            rs2_val = wb_data;
        end
`endif
    end

    // Load-use hazard against the load sitting in EX; a flush wins so IF can redirect.
    always_comb begin
        stall_c = valid_ifid && idex_q.valid && idex_q.memread && (idex_q.rd != 5'd0)
                  && ((use_rs1 && (idex_q.rd == rs1_f)) || (use_rs2 && (idex_q.rd == rs2_f)))
                  && !flush_i;
    end

    assign stall_o = stall_c;

    // ID/EX next state: bubble on flush/stall, otherwise capture the decode.
    always_comb begin
        idex_d   = '0;
        bubble_d = bubble_q;
        if (flush_i || stall_c) begin
            if (bubble_q != BUB_MAX) begin
                bubble_d = bubble_q + CNT_W'(1);
            end
        end else begin
            idex_d.valid    = valid_ifid;
            idex_d.rs1_data = rs1_val;
            idex_d.rs2_data = rs2_val;
            idex_d.imm      = dec_imm;
            idex_d.pc       = pc_ifid;
            idex_d.instr    = instr_ifid;
            idex_d.rd       = rd_f;
            idex_d.rs1      = rs1_f;
            idex_d.rs2      = rs2_f;
            if (valid_ifid) begin
                idex_d.branch   = dec_branch;
                idex_d.memread  = dec_memread;
                idex_d.mem2reg  = dec_mem2reg;
                idex_d.memwrite = dec_memwrite;
                idex_d.alusrc   = dec_alusrc;
                idex_d.regwrite = dec_regwrite;
                idex_d.aluop    = dec_aluop;
            end
        end
    end

    // ID/EX pipeline register and bubble counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idex_q   <= '0;
            bubble_q <= '0;
        end else begin
            idex_q   <= idex_d;
            bubble_q <= bubble_d;
        end
    end

    assign valid_idex    = idex_q.valid;
    assign rs1_data_idex = idex_q.rs1_data;
    assign rs2_data_idex = idex_q.rs2_data;
    assign imm_idex      = idex_q.imm;
    assign pc_idex       = idex_q.pc;
    assign instr_idex    = idex_q.instr;
    assign rd_idex       = idex_q.rd;
    assign rs1_idex      = idex_q.rs1;
    assign rs2_idex      = idex_q.rs2;
    assign branch_idex   = idex_q.branch;
    assign memread_idex  = idex_q.memread;
    assign mem2reg_idex  = idex_q.mem2reg;
    assign memwrite_idex = idex_q.memwrite;
    assign alusrc_idex   = idex_q.alusrc;
    assign regwrite_idex = idex_q.regwrite;
    assign aluop_idex    = idex_q.aluop;
    assign bubble_cnt    = bubble_q;

endmodule

// File: tb/tb_id_stage_hz.sv
// Testbench for id_stage_hz: directed scenarios plus randomized traffic, with
// expected ID/EX contents from a reference model queued to a scoreboard monitor.
module tb_id_stage_hz;

    localparam int unsigned CW   = 3;
    localparam int          BMAX = (1 << CW) - 1;

    typedef struct packed {
        logic          valid;
        logic [31:0]   rs1d;
        logic [31:0]   rs2d;
        logic [31:0]   imm;
        logic [31:0]   pc;
        logic [31:0]   instr;
        logic [4:0]    rd;
        logic [4:0]    rs1;
        logic [4:0]    rs2;
        logic          branch;
        logic          memread;
        logic          mem2reg;
        logic          memwrite;
        logic          alusrc;
        logic          regwrite;
        logic [1:0]    aluop;
        logic [CW-1:0] bub;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   instr_ifid = '0;
    logic [31:0]   pc_ifid = '0;
    logic          valid_ifid = 1'b0;
    logic          flush_i = 1'b0;
    logic          wb_we = 1'b0;
    logic [4:0]    wb_rd = '0;
    logic [31:0]   wb_data = '0;
    logic          stall_o, valid_idex;
    logic [31:0]   rs1_data_idex, rs2_data_idex, imm_idex, pc_idex, instr_idex;
    logic [4:0]    rd_idex, rs1_idex, rs2_idex;
    logic          branch_idex, memread_idex, mem2reg_idex, memwrite_idex;
    logic          alusrc_idex, regwrite_idex;
    logic [1:0]    aluop_idex;
    logic [CW-1:0] bubble_cnt;

    id_stage_hz #(.XLEN(32), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .instr_ifid(instr_ifid), .pc_ifid(pc_ifid),
        .valid_ifid(valid_ifid), .flush_i(flush_i), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .stall_o(stall_o), .valid_idex(valid_idex),
        .rs1_data_idex(rs1_data_idex), .rs2_data_idex(rs2_data_idex),
        .imm_idex(imm_idex), .pc_idex(pc_idex), .instr_idex(instr_idex),
        .rd_idex(rd_idex), .rs1_idex(rs1_idex), .rs2_idex(rs2_idex),
        .branch_idex(branch_idex), .memread_idex(memread_idex),
        .mem2reg_idex(mem2reg_idex), .memwrite_idex(memwrite_idex),
        .alusrc_idex(alusrc_idex), .regwrite_idex(regwrite_idex),
        .aluop_idex(aluop_idex), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        sb[$];

    // Reference model state: architectural registers plus what sits in EX.
    logic [31:0] m_rf [32];
    logic        m_valid = 1'b0, m_memread = 1'b0, m_known = 1'b0;
    logic [4:0]  m_rd = '0;
    int          m_bub = 0;
    logic [31:0] cur_pc = 32'h1000;

    // Instruction class: 0 R, 1 I-ALU, 2 load, 3 store, 4 branch, 5 other.
    function automatic int kind_of(input logic [6:0] op);
        case (op)
            7'b0110011: return 0;
            7'b0010011: return 1;
            7'b0000011: return 2;
            7'b0100011: return 3;
            7'b1100011: return 4;
            default:    return 5;
        endcase
    endfunction

    function automatic logic [31:0] imm_of(input logic [31:0] ins);
        int k, v;
        k = kind_of(ins[6:0]);
        v = 0;
        if (k == 1 || k == 2) begin
            v = int'(ins[31:20]);
            if (v >= 2048) v -= 4096;
        end else if (k == 3) begin
            v = int'(ins[31:25]) * 32 + int'(ins[11:7]);
            if (v >= 2048) v -= 4096;
        end else if (k == 4) begin
            v = int'(ins[31]) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
                + int'(ins[11:8]) * 2;
            if (v >= 4096) v -= 8192;
        end
        return 32'(v);
    endfunction

    function automatic logic [31:0] read_reg(input logic [4:0] idx, input logic we,
                                             input logic [4:0] wrd, input logic [31:0] wd);
        if (idx == 5'd0) return 32'd0;
`ifdef ID_WB_BYPASS_EN
        if (we && wrd == idx) return wd;
`endif
        return m_rf[idx];
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] a,
                                          input logic [4:0] b);
        return {7'd0, b, a, 3'd0, rd, 7'b0110011};
    endfunction

    // One cycle: drive inputs, check stall_o, queue the expected ID/EX contents.
    task automatic step(input logic r, input logic [31:0] ins, input logic v,
                        input logic fl, input logic we, input logic [4:0] wrd,
                        input logic [31:0] wd, output logic st);
        exp_t       e;
        int         k;
        logic       u1, u2;
        logic [4:0] a, b;
        @(negedge clk);
        rst_n = !r; instr_ifid = ins; pc_ifid = cur_pc; valid_ifid = v; flush_i = fl;
        wb_we = we; wb_rd = wrd; wb_data = wd;
        #1;
        k  = kind_of(ins[6:0]);
        a  = ins[19:15];
        b  = ins[24:20];
        u1 = (k <= 4);
        u2 = (k == 0 || k == 3 || k == 4);
        st = v && m_valid && m_memread && (m_rd != 5'd0)
             && ((u1 && m_rd == a) || (u2 && m_rd == b)) && !fl;
        if (m_known) begin
            n_cmp++;
            if (stall_o !== st) begin
                n_bad++;
                $display("FAIL stall_o t=%0t got=%b exp=%b", $time, stall_o, st);
            end
        end
        e = '0;
        if (r) begin
            for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
            m_bub = 0;
        end else begin
            if (fl || st) begin
                if (m_bub < BMAX) m_bub++;
            end else begin
                e.valid = v;
                e.rs1d  = read_reg(a, we, wrd, wd);
                e.rs2d  = read_reg(b, we, wrd, wd);
                e.imm   = imm_of(ins);
                e.pc    = cur_pc;
                e.instr = ins;
                e.rd    = ins[11:7];
                e.rs1   = a;
                e.rs2   = b;
                if (v) begin
                    e.branch   = (k == 4);
                    e.memread  = (k == 2);
                    e.mem2reg  = (k == 2);
                    e.memwrite = (k == 3);
                    e.alusrc   = (k == 1 || k == 2 || k == 3);
                    e.regwrite = (k <= 2);
                    e.aluop    = (k == 0) ? 2'd2 : (k == 1) ? 2'd3 : (k == 4) ? 2'd1 : 2'd0;
                end
            end
            if (we && wrd != 5'd0) m_rf[wrd] = wd;
        end
        e.bub     = CW'(m_bub);
        m_valid   = e.valid;
        m_memread = e.memread;
        m_rd      = e.rd;
        m_known   = 1'b1;
        sb.push_back(e);
    endtask

    // Issue an instruction, holding it in IF/ID while a stall is expected.
    task automatic issue(input logic [31:0] ins, input logic fl, input logic we,
                         input logic [4:0] wrd, input logic [31:0] wd);
        logic st;
        int   n;
        n = 0;
        do begin
            step(1'b0, ins, 1'b1, fl, we, wrd, wd, st);
            n++;
        end while (st && n < 4);
        cur_pc += 32'd4;
    endtask

    task automatic idle(input logic we, input logic [4:0] wrd, input logic [31:0] wd);
        logic st;
        step(1'b0, 32'd0, 1'b0, 1'b0, we, wrd, wd, st);
    endtask

    // Scoreboard monitor: one comparison of the whole ID/EX state per edge.
    initial begin
        exp_t e, g;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                g = {valid_idex, rs1_data_idex, rs2_data_idex, imm_idex, pc_idex, instr_idex,
                     rd_idex, rs1_idex, rs2_idex, branch_idex, memread_idex, mem2reg_idex,
                     memwrite_idex, alusrc_idex, regwrite_idex, aluop_idex, bubble_cnt};
                n_cmp++;
                if (g !== e) begin
                    n_bad++;
                    $display("FAIL idex t=%0t got=%h exp=%h", $time, g, e);
                end
            end
        end
    end

    initial begin
        logic        st, hold;
        logic [31:0] ins;
        logic [6:0]  ops [6];
        int          t;
        ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011;
        ops[3] = 7'b0100011; ops[4] = 7'b1100011; ops[5] = 7'b1101111;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;

        repeat (3) step(1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, st);
        idle(1'b1, 5'd5, 32'h1234);
        idle(1'b1, 5'd1, 32'h100);
        idle(1'b1, 5'd2, 32'h22);
        idle(1'b1, 5'd9, 32'h1111);
        issue(enc_r(5'd6, 5'd5, 5'd5), 1'b0, 1'b0, 5'd0, 32'd0);
        // Load-use: one stall cycle, then the add issues.
        issue(32'hFFC0A383, 1'b0, 1'b0, 5'd0, 32'd0);
        issue(enc_r(5'd8, 5'd7, 5'd2), 1'b0, 1'b0, 5'd0, 32'd0);
        // Load to x0 never creates a hazard.
        issue({12'd0, 5'd1, 3'b010, 5'd0, 7'b0000011}, 1'b0, 1'b0, 5'd0, 32'd0);
        issue(enc_r(5'd8, 5'd0, 5'd2), 1'b0, 1'b0, 5'd0, 32'd0);
        // Flush together with a load-use condition.
        issue(32'hFFC0A383, 1'b0, 1'b0, 5'd0, 32'd0);
        issue(enc_r(5'd8, 5'd7, 5'd2), 1'b1, 1'b0, 5'd0, 32'd0);
        // Same-cycle writeback to a register being read; writeback to x0.
        issue(enc_r(5'd10, 5'd9, 5'd0), 1'b0, 1'b1, 5'd9, 32'hDEAD);
        idle(1'b1, 5'd0, 32'hFFFF);
        issue(enc_r(5'd11, 5'd0, 5'd0), 1'b0, 1'b0, 5'd0, 32'd0);
        // Immediate formats: branch, store, negative I-ALU.
        issue(32'hFE000EE3, 1'b0, 1'b0, 5'd0, 32'd0);
        issue({7'd0, 5'd5, 5'd2, 3'b010, 5'b01000, 7'b0100011}, 1'b0, 1'b0, 5'd0, 32'd0);
        issue({12'hFFF, 5'd5, 3'd0, 5'd3, 7'b0010011}, 1'b0, 1'b0, 5'd0, 32'd0);
        // Drive the bubble counter into saturation.
        repeat (9) issue(enc_r(5'd4, 5'd1, 5'd2), 1'b1, 1'b0, 5'd0, 32'd0);
        // Reset arriving while a stall is asserted.
        issue(32'hFFC0A383, 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b0, enc_r(5'd8, 5'd7, 5'd2), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, st);
        step(1'b1, enc_r(5'd8, 5'd7, 5'd2), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, st);
        step(1'b0, enc_r(5'd8, 5'd7, 5'd2), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, st);

        // Randomized traffic on a small register window to provoke hazards.
        hold = 1'b0;
        ins  = 32'd0;
        for (int i = 0; i < 400; i++) begin
            if (!hold) begin
                ins        = $urandom;
                ins[6:0]   = ops[$urandom_range(5, 0)];
                ins[11:7]  = 5'($urandom_range(3, 0));
                ins[19:15] = 5'($urandom_range(3, 0));
                ins[24:20] = 5'($urandom_range(3, 0));
                cur_pc    += 32'd4;
            end
            step(1'b0, ins, ($urandom_range(7, 0) != 0), ($urandom_range(11, 0) == 0),
                 1'($urandom_range(1, 0)), 5'($urandom_range(7, 0)), $urandom, st);
            hold = st;
        end
        idle(1'b0, 5'd0, 32'd0);

        t = 0;
        while (sb.size() != 0 && t < 10) begin
            @(posedge clk);
            #2;
            t++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain pending=%0d exp=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
